fetch_queue: RTL and testbench

- Small in-order instruction buffer between the fetch stage and the decode stage.
- Captures {pc, instr} pairs from fetch/instruction memory and presents them to decode through a valid/ready handshake.
- Absorbs decode stalls without dropping fetched instructions.
- Discards every buffered entry on a control-flow redirect (flush), issued when fetch is steered to a new PC target.

---
 rtl/fetch_queue_if.sv | 29 ++
 rtl/fetch_queue.sv | 62 ++++++
 tb/tb_fetch_queue.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Fetch-to-decode handshake bundle: enqueue side from fetch, dequeue side to decode.
interface fetch_queue_if #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic             enq_valid;
    logic             enq_ready;
    logic [WIDTH-1:0] enq_pc;
    logic [WIDTH-1:0] enq_instr;
    logic             deq_valid;
    logic             deq_ready;
    logic [WIDTH-1:0] deq_pc;
    logic [WIDTH-1:0] deq_instr;
    logic [CNT_W-1:0] count;

    // Driver side: fetch offers entries and decode consumes them.
    modport master (
        output enq_valid, enq_pc, enq_instr, deq_ready,
        input  enq_ready, deq_valid, deq_pc, deq_instr, count
    );

    // The queue itself.
    modport slave (
        input  enq_valid, enq_pc, enq_instr, deq_ready,
        output enq_ready, deq_valid, deq_pc, deq_instr, count
    );
endinterface

// File: rtl/fetch_queue.sv
// In-order {pc, instr} buffer between fetch and decode; flush empties it on a redirect.
module fetch_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    fetch_queue_if.slave  bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [WIDTH-1:0] pc;
        logic [WIDTH-1:0] instr;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [CNT_W-1:0] count_q;

    logic full;
    logic empty;
    logic enq_fire;
    logic deq_fire;

    // Ready/valid come purely from the registered occupancy, so a dequeue never opens a same-cycle slot.
    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == CNT_W'(0));
    assign enq_fire = bus.enq_valid && !full;
    assign deq_fire = bus.deq_ready && !empty;

    assign bus.enq_ready = !full;
    assign bus.deq_valid = !empty;
    assign bus.deq_pc    = mem[head_q].pc;
    assign bus.deq_instr = mem[head_q].instr;
    assign bus.count     = count_q;

    // Pointer and occupancy update; reset outranks flush, flush discards any same-cycle traffic.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            head_q  <= PTR_W'(0);
            tail_q  <= PTR_W'(0);
            count_q <= CNT_W'(0);
        end else begin
            if (enq_fire) tail_q <= tail_q + PTR_W'(1);
            if (deq_fire) head_q <= head_q + PTR_W'(1);
            if (enq_fire && !deq_fire)
                count_q <= count_q + CNT_W'(1);
            else if (deq_fire && !enq_fire)
                count_q <= count_q - CNT_W'(1);
        end
    end

    // Entry storage is not reset; writes are suppressed during reset and flush.
    always_ff @(posedge clk) begin
        if (!reset && !flush && enq_fire)
            mem[tail_q] <= '{pc: bus.enq_pc, instr: bus.enq_instr};
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: stimulus pushes expected entries, a negedge monitor pops and compares.
module tb_fetch_queue;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned WIDTH = 32;

    logic clk;
    logic reset;
    logic flush;

    fetch_queue_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

    fetch_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int m_cnt    = 0;
    int m_deqs   = 0;
    int mon_deqs = 0;
    logic [63:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every decode handshake must present the oldest outstanding entry.
    always @(negedge clk) begin
        if (bus.deq_valid === 1'b1 && bus.deq_ready === 1'b1) begin
            logic [63:0] e;
            mon_deqs++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL deq_unexpected: got pc 0x%08h, expected no entry at %0t", bus.deq_pc, $time);
            end else begin
                e = exp_q.pop_front();
                check("deq_pc", bus.deq_pc, e[63:32]);
                check("deq_instr", bus.deq_instr, e[31:0]);
            end
        end
    end

    // One clock of stimulus; model advances at the edge, then the occupancy outputs are compared.
    task automatic step(input logic ev, input logic [31:0] pc, input logic [31:0] ins,
                        input logic dr, input logic fl, input logic rs);
        bit enq_ok;
        bit deq_ok;
        int nxt;
        reset         = rs;
        flush         = fl;
        bus.enq_valid = ev;
        bus.enq_pc    = pc;
        bus.enq_instr = ins;
        bus.deq_ready = dr;
        enq_ok = ev && (m_cnt < int'(DEPTH));
        deq_ok = dr && (m_cnt > 0);
        if (deq_ok) m_deqs++;
        if (rs || fl) nxt = 0;
        else          nxt = m_cnt + int'(enq_ok) - int'(deq_ok);
        if (!rs && !fl && enq_ok) exp_q.push_back({pc, ins});
        @(posedge clk);
        #1;
        if (rs || fl) exp_q.delete();
        m_cnt = nxt;
        check("count", 32'(bus.count), 32'(m_cnt));
        check("enq_ready", 32'(bus.enq_ready), 32'(m_cnt != int'(DEPTH)));
        check("deq_valid", 32'(bus.deq_valid), 32'(m_cnt != 0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] pcs [4];
        logic [31:0] ins [4];
        pcs = '{32'h00, 32'h04, 32'h08, 32'h0C};
        ins = '{32'h00000013, 32'h00500093, 32'h00A00113, 32'h002081B3};

        // Reset state
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_enq_ready", 32'(bus.enq_ready), 32'd1);

        // Fill to full with decode stalled
        for (int i = 0; i < 4; i++) begin
            step(1'b1, pcs[i], ins[i], 1'b0, 1'b0, 1'b0);
            check("fill_count", 32'(bus.count), 32'(i + 1));
        end
        check("full_enq_ready", 32'(bus.enq_ready), 32'd0);
        check("full_head_pc", bus.deq_pc, 32'h00);
        check("full_head_instr", bus.deq_instr, 32'h00000013);

        // Full: same-cycle dequeue must not admit pc 0x10
        step(1'b1, 32'h10, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0);
        check("full_deq_count", 32'(bus.count), 32'd3);
        check("full_deq_ready", 32'(bus.enq_ready), 32'd1);
        check("full_deq_head", bus.deq_pc, 32'h04);

        // Drain, then a steady enqueue+dequeue stream across pointer wrap
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        check("drained", 32'(bus.count), 32'd0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i), 1'b1, 1'b0, 1'b0);
            check("stream_count", 32'(bus.count), 32'd1);
        end
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Flush at count=3 with concurrent enqueue and dequeue
        for (int i = 0; i < 3; i++) step(1'b1, 32'h20 + 32'(4 * i), 32'hB000_0000 + 32'(i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h200, 32'hC0DE0200, 1'b1, 1'b1, 1'b0);
        check("flush_count", 32'(bus.count), 32'd0);
        check("flush_valid", 32'(bus.deq_valid), 32'd0);
        step(1'b1, 32'h300, 32'hC0DE0300, 1'b0, 1'b0, 1'b0);
        check("post_flush_head", bus.deq_pc, 32'h300);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Reset mid-stream beats simultaneous flush and enqueue
        step(1'b1, 32'h50, 32'h00000050, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h54, 32'h00000054, 1'b0, 1'b0, 1'b0);
        check("pre_reset_count", 32'(bus.count), 32'd2);
        step(1'b1, 32'h58, 32'h00000058, 1'b1, 1'b1, 1'b1);
        check("mid_reset_count", 32'(bus.count), 32'd0);
        check("mid_reset_ready", 32'(bus.enq_ready), 32'd1);

        // Empty: deq_ready ignored, then a single enqueue with no bypass
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
            check("empty_count", 32'(bus.count), 32'd0);
        end
        step(1'b1, 32'h40, 32'h00000040, 1'b1, 1'b0, 1'b0);
        check("late_head_pc", bus.deq_pc, 32'h40);
        check("late_head_instr", bus.deq_instr, 32'h00000040);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Nothing outstanding and every expected handshake observed
        @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check("deq_handshakes", 32'(mon_deqs), 32'(m_deqs));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
